// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flexible synchronous FIFO: count width and
// explicit-wrap pointer increment for depths that need not be a power of two.
package sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_inc(input int ptr, input int depth);
    if (ptr >= depth - 1) begin
      return 0;
    end else begin
      return ptr + 1;
    end
  endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// WIDTH x DEPTH register array with one synchronous write port and one
// asynchronous read port.
module fifo_ram_sp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex_chk.sv
// Structural invariants of the FIFO occupancy flags.
module sync_fifo_flex_chk #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          full_i,
  input logic          empty_i,
  input logic [CW-1:0] count_i
);

  a_not_full_and_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(full_i && empty_i));

  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    count_i <= CW'(DEPTH));

  a_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    full_i == (count_i == CW'(DEPTH)));

  a_empty_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    empty_i == (count_i == {CW{1'b0}}));

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, programmable thresholds, occupancy
// count, sticky error flags and selectable standard / first-word-fall-through reads.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int CW      = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  fifo_flags_t      flags_q, flags_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rvalid_q, rvalid_d;
  logic             wr_acc_s, rd_acc_s;
  logic [WIDTH-1:0] ram_rdata_s;

  fifo_ram_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata_s)
  );

  // Accept decisions from pre-edge flags; a read frees the slot a full write needs.
  always_comb begin
    rd_acc_s = rd_en & ~flags_q.empty;
    wr_acc_s = wr_en & (~flags_q.full | rd_acc_s);
  end

  // Pointer, occupancy and flag next-state; flags follow next-count so they align with count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc_s) begin
      wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    flags_d.full         = (count_d == CW'(DEPTH));
    flags_d.empty        = (count_d == {CW{1'b0}});
    flags_d.almost_full  = (count_d >= CW'(AF_LEVEL));
    flags_d.almost_empty = (count_d <= CW'(AE_LEVEL));
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
      udf_d = udf_q;
    end
    if (wr_en & ~wr_acc_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (rd_en & flags_q.empty) begin
      udf_d = 1'b1;
    end else begin
      udf_d = udf_d;
    end
  end

  // Standard-mode read register: capture head on an accepted read, hold otherwise.
  always_comb begin
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    if (FWFT == 0) begin
      if (rd_acc_s) begin
        dout_d   = ram_rdata_s;
        rvalid_d = 1'b1;
      end else begin
        dout_d   = dout_q;
        rvalid_d = 1'b0;
      end
    end else begin
      dout_d   = {WIDTH{1'b0}};
      rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      flags_q  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= {WIDTH{1'b0}};
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  // In FWFT mode the head is presented straight from the array; blanked while empty.
  assign data_out     = (FWFT != 0) ? (flags_q.empty ? {WIDTH{1'b0}} : ram_rdata_s) : dout_q;
  assign rd_valid     = (FWFT != 0) ? ~flags_q.empty : rvalid_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  sync_fifo_flex_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .full_i  (flags_q.full),
    .empty_i (flags_q.empty),
    .count_i (count_q)
  );

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: table-driven vectors on a standard-mode instance plus
// hand sequences for reset, non-power-of-two wrap and FWFT behaviour.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // standard mode, DEPTH 8
  logic       s_rst_n, s_wr, s_rd, s_clr;
  logic [7:0] s_din, s_dout;
  logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [3:0] s_cnt;
  // standard mode, DEPTH 6
  logic       d_rst_n, d_wr, d_rd, d_clr;
  logic [7:0] d_din, d_dout;
  logic       d_rv, d_full, d_empty, d_af, d_ae, d_ovf, d_udf;
  logic [2:0] d_cnt;
  // FWFT mode, DEPTH 8
  logic       f_rst_n, f_wr, f_rd, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] f_cnt;

  sync_fifo_flex #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(s_rst_n), .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd),
    .data_out(s_dout), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf), .err_clr(s_clr));

  sync_fifo_flex #(.WIDTH(8), .DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d6 (
    .clk(clk), .rst_n(d_rst_n), .wr_en(d_wr), .data_in(d_din), .rd_en(d_rd),
    .data_out(d_dout), .rd_valid(d_rv), .full(d_full), .empty(d_empty),
    .almost_full(d_af), .almost_empty(d_ae), .count(d_cnt),
    .overflow(d_ovf), .underflow(d_udf), .err_clr(d_clr));

  sync_fifo_flex #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(f_rst_n), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
    .data_out(f_dout), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf), .err_clr(f_clr));

  // flags packed as {full, empty, almost_full, almost_empty, overflow, underflow}
  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [7:0] dout;
    logic       rv;
    logic [3:0] cnt;
    logic [5:0] fl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [7:0] din, input logic rd, input logic clr,
                     input logic [7:0] dout, input logic rv, input logic [3:0] cnt,
                     input logic [5:0] fl);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
    v.dout = dout; v.rv = rv; v.cnt = cnt; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic s_step(input logic rst_n, input logic wr, input logic [7:0] din,
                        input logic rd, input logic clr);
    @(negedge clk);
    s_rst_n = rst_n; s_wr = wr; s_din = din; s_rd = rd; s_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic d_step(input logic wr, input logic [7:0] din, input logic rd);
    @(negedge clk);
    d_wr = wr; d_din = din; d_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic f_step(input logic wr, input logic [7:0] din, input logic rd);
    @(negedge clk);
    f_wr = wr; f_din = din; f_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic s_check_all(input string tag, input logic [7:0] dout, input logic rv,
                             input logic [3:0] cnt, input logic [5:0] fl);
    chk({tag, ".data_out"}, s_dout, dout);
    chk({tag, ".rd_valid"}, s_rv, rv);
    chk({tag, ".count"}, s_cnt, cnt);
    chk({tag, ".flags"}, {s_full, s_empty, s_af, s_ae, s_ovf, s_udf}, fl);
  endtask

  logic [7:0] mdl[$];
  logic [7:0] exp_b;

  initial begin
    s_rst_n = 1'b0; s_wr = 1'b0; s_din = 8'h00; s_rd = 1'b0; s_clr = 1'b0;
    d_rst_n = 1'b0; d_wr = 1'b0; d_din = 8'h00; d_rd = 1'b0; d_clr = 1'b0;
    f_rst_n = 1'b0; f_wr = 1'b0; f_din = 8'h00; f_rd = 1'b0; f_clr = 1'b0;

    // fill to full, overflow attempt
    add(1, 8'h1A, 0, 0, 8'h00, 0, 4'd1, 6'b000100);
    add(1, 8'h35, 0, 0, 8'h00, 0, 4'd2, 6'b000100);
    add(1, 8'h4F, 0, 0, 8'h00, 0, 4'd3, 6'b000000);
    add(1, 8'hA1, 0, 0, 8'h00, 0, 4'd4, 6'b000000);
    add(1, 8'h23, 0, 0, 8'h00, 0, 4'd5, 6'b000000);
    add(1, 8'h37, 0, 0, 8'h00, 0, 4'd6, 6'b001000);
    add(1, 8'h99, 0, 0, 8'h00, 0, 4'd7, 6'b001000);
    add(1, 8'h0B, 0, 0, 8'h00, 0, 4'd8, 6'b101000);
    add(1, 8'h72, 0, 0, 8'h00, 0, 4'd8, 6'b101010);
    // drain nine times, last one underflows; then clear
    add(0, 8'h00, 1, 0, 8'h1A, 1, 4'd7, 6'b001010);
    add(0, 8'h00, 1, 0, 8'h35, 1, 4'd6, 6'b001010);
    add(0, 8'h00, 1, 0, 8'h4F, 1, 4'd5, 6'b000010);
    add(0, 8'h00, 1, 0, 8'hA1, 1, 4'd4, 6'b000010);
    add(0, 8'h00, 1, 0, 8'h23, 1, 4'd3, 6'b000010);
    add(0, 8'h00, 1, 0, 8'h37, 1, 4'd2, 6'b000110);
    add(0, 8'h00, 1, 0, 8'h99, 1, 4'd1, 6'b000110);
    add(0, 8'h00, 1, 0, 8'h0B, 1, 4'd0, 6'b010110);
    add(0, 8'h00, 1, 0, 8'h0B, 0, 4'd0, 6'b010111);
    add(0, 8'h00, 0, 1, 8'h0B, 0, 4'd0, 6'b010100);
    // refill, then simultaneous write+read while full
    add(1, 8'h1A, 0, 0, 8'h0B, 0, 4'd1, 6'b000100);
    add(1, 8'h35, 0, 0, 8'h0B, 0, 4'd2, 6'b000100);
    add(1, 8'h4F, 0, 0, 8'h0B, 0, 4'd3, 6'b000000);
    add(1, 8'hA1, 0, 0, 8'h0B, 0, 4'd4, 6'b000000);
    add(1, 8'h23, 0, 0, 8'h0B, 0, 4'd5, 6'b000000);
    add(1, 8'h37, 0, 0, 8'h0B, 0, 4'd6, 6'b001000);
    add(1, 8'h99, 0, 0, 8'h0B, 0, 4'd7, 6'b001000);
    add(1, 8'h0B, 0, 0, 8'h0B, 0, 4'd8, 6'b101000);
    add(1, 8'h55, 1, 0, 8'h1A, 1, 4'd8, 6'b101000);
    add(0, 8'h00, 1, 0, 8'h35, 1, 4'd7, 6'b001000);
    add(0, 8'h00, 1, 0, 8'h4F, 1, 4'd6, 6'b001000);
    add(0, 8'h00, 1, 0, 8'hA1, 1, 4'd5, 6'b000000);
    add(0, 8'h00, 1, 0, 8'h23, 1, 4'd4, 6'b000000);
    add(0, 8'h00, 1, 0, 8'h37, 1, 4'd3, 6'b000000);
    add(0, 8'h00, 1, 0, 8'h99, 1, 4'd2, 6'b000100);
    add(0, 8'h00, 1, 0, 8'h0B, 1, 4'd1, 6'b000100);
    add(0, 8'h00, 1, 0, 8'h55, 1, 4'd0, 6'b010100);
    // read+write on empty: write accepted, read rejected, underflow
    add(1, 8'h66, 1, 0, 8'h55, 0, 4'd1, 6'b000101);
    add(0, 8'h00, 1, 0, 8'h66, 1, 4'd0, 6'b010101);
    // clear coinciding with a new underflow: set wins
    add(0, 8'h00, 1, 1, 8'h66, 0, 4'd0, 6'b010101);
    add(0, 8'h00, 0, 1, 8'h66, 0, 4'd0, 6'b010100);

    // reset state of all instances
    s_step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    s_step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    s_rst_n = 1'b1; d_rst_n = 1'b1; f_rst_n = 1'b1;
    #1;
    s_check_all("reset", 8'h00, 1'b0, 4'd0, 6'b010100);
    chk("d6_reset.count", d_cnt, 3'd0);
    chk("fw_reset.empty_rv", {f_empty, f_rv, f_dout}, {1'b1, 1'b0, 8'h00});

    for (int i = 0; i < vecs.size(); i++) begin
      s_step(1'b1, vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
      s_check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rv, vecs[i].cnt, vecs[i].fl);
    end

    // mid-operation reset discards contents; new data is not stale
    for (int i = 0; i < 5; i++) begin
      s_step(1'b1, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    end
    chk("prereset.count", s_cnt, 4'd5);
    s_step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    s_check_all("midreset", 8'h00, 1'b0, 4'd0, 6'b010100);
    s_step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    chk("postreset_wr.count", s_cnt, 4'd1);
    s_step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    s_check_all("postreset_rd", 8'hC3, 1'b1, 4'd0, 6'b010100);

    // DEPTH 6: prefill 3, then 20 simultaneous write/read pairs across the wrap
    for (int i = 0; i < 3; i++) begin
      d_step(1'b1, 8'h10 + 8'(i), 1'b0);
      mdl.push_back(8'h10 + 8'(i));
    end
    chk("d6_prefill.count", d_cnt, 3'd3);
    for (int i = 0; i < 20; i++) begin
      d_step(1'b1, 8'h40 + 8'(i * 3), 1'b1);
      exp_b = mdl.pop_front();
      mdl.push_back(8'h40 + 8'(i * 3));
      chk($sformatf("d6_pair%0d.data_out", i), {d_rv, d_dout}, {1'b1, exp_b});
      chk($sformatf("d6_pair%0d.count", i), d_cnt, 3'd3);
    end
    for (int i = 0; i < 4; i++) begin
      d_step(1'b1, 8'hD0 + 8'(i), 1'b0);
      if (mdl.size() < 6) mdl.push_back(8'hD0 + 8'(i));
    end
    chk("d6_full.count", d_cnt, 3'd6);
    chk("d6_full.flags", {d_full, d_empty, d_ovf}, 3'b101);
    for (int i = 0; i < 6; i++) begin
      d_step(1'b0, 8'h00, 1'b1);
      exp_b = mdl.pop_front();
      chk($sformatf("d6_drain%0d.data_out", i), {d_rv, d_dout}, {1'b1, exp_b});
    end
    chk("d6_drained.empty", {d_empty, d_cnt}, {1'b1, 3'd0});

    // FWFT: write on empty appears next cycle with no bubble
    f_step(1'b1, 8'h1A, 1'b0);
    chk("fw_wr1.head", {f_rv, f_dout, f_cnt}, {1'b1, 8'h1A, 4'd1});
    f_step(1'b0, 8'h00, 1'b1);
    chk("fw_pop1.empty", {f_empty, f_rv, f_cnt}, {1'b1, 1'b0, 4'd0});
    f_step(1'b1, 8'h35, 1'b1);
    chk("fw_wr_rd_empty", {f_udf, f_rv, f_dout, f_cnt}, {1'b1, 1'b1, 8'h35, 4'd1});
    f_step(1'b1, 8'h4F, 1'b0);
    chk("fw_wr2.head_holds", {f_dout, f_cnt}, {8'h35, 4'd2});
    f_step(1'b0, 8'h00, 1'b1);
    chk("fw_pop2.next_head", {f_rv, f_dout, f_cnt}, {1'b1, 8'h4F, 4'd1});
    f_step(1'b0, 8'h00, 1'b1);
    chk("fw_pop3.empty", {f_empty, f_rv}, {1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
